flag_bank_arbiter: RTL and testbench

//   Round-robin write arbiter for a bank of NUM_CELL generated single-bit flag cells.
//   NUM_REQ requesters each ask to write a 1-bit value into one indexed cell.
//   One write is granted every two cycles; the cells are driven only from this block.

---
 rtl/flag_bank_pkg.sv | 29 ++
 rtl/flag_bank_arbiter_flag_cell.sv | 24 ++
 rtl/flag_bank_arbiter.sv | 129 ++++++++++++
 tb/tb_flag_bank_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/flag_bank_pkg.sv
// Shared types and the round-robin pick helper for the flag bank arbiter.
package flag_bank_pkg;

  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef enum logic {ST_IDLE, ST_WRITE} fb_state_e;

  // First set bit of req at or above ptr, wrapping modulo n (n <= RR_MAX).
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX-1:0]   req,
                                                  input logic [RR_IDX_W-1:0] ptr,
                                                  input logic [RR_IDX_W:0]   n);
    logic [RR_IDX_W-1:0] win;
    logic                found;
    logic [RR_IDX_W:0]   k;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      k = {1'b0, ptr} + (RR_IDX_W+1)'(i);
      if (k >= n) k = k - n;
      if (((RR_IDX_W+1)'(i) < n) && !found && req[k[RR_IDX_W-1:0]]) begin
        win   = k[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/flag_bank_arbiter_flag_cell.sv
// One flag bit: async-reset register, loaded when we is high.
module flag_cell (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic d,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we) q_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/flag_bank_arbiter.sv
// Round-robin write arbiter driving a bank of flag_cell instances, one grant per two cycles.
// Optional sticky out-of-range error flag built only when FLAG_BANK_ERR_EN is defined.
module flag_bank_arbiter
  import flag_bank_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_CELL = 4,
  parameter int IDX_W    = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  input  logic [NUM_REQ-1:0]       req_val,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [NUM_CELL-1:0]      flags,
  output logic                     err
);

  fb_state_e           state_q, state_d;
  logic [RR_IDX_W-1:0] winner_q, winner_d;
  logic [RR_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                val_q, val_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;

  logic [RR_MAX-1:0]   req_ext;
  logic [RR_IDX_W-1:0] win;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_val;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
    win     = rr_pick(req_ext, rr_ptr_q, (RR_IDX_W+1)'(NUM_REQ));
    sel_idx = '0;
    sel_val = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (win == RR_IDX_W'(r)) begin
        sel_idx = req_idx[r*IDX_W +: IDX_W];
        sel_val = req_val[r];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    val_d    = val_q;
    ack_d    = '0;
    busy_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          winner_d = win;
          idx_d    = sel_idx;
          val_d    = sel_val;
          for (int r = 0; r < NUM_REQ; r++) ack_d[r] = (win == RR_IDX_W'(r));
          busy_d   = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        rr_ptr_d = (winner_q == RR_IDX_W'(NUM_REQ-1)) ? '0 : winner_q + 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      val_q    <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign ack  = ack_q;
  assign busy = busy_q;

`ifdef FLAG_BANK_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && (|req) && ({1'b0, sel_idx} >= (IDX_W+1)'(NUM_CELL)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // An out-of-range idx_q matches no cell, so that write is dropped.
  for (genvar i = 0; i < NUM_CELL; i++) begin : cell_g
    logic we_c;
    assign we_c = (state_q == ST_WRITE) && (idx_q == IDX_W'(i));
    flag_cell u_cell (
      .clk (clk),
      .rst (rst),
      .we  (we_c),
      .d   (val_q),
      .q   (flags[i])
    );
  end

endmodule

// File: tb/tb_flag_bank_arbiter.sv
// Directed plus randomized bench for flag_bank_arbiter against a transaction-level model.
module tb_flag_bank_arbiter;

  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int IW  = 2;
  localparam int NR3 = 2;
  localparam int NC3 = 3;
  localparam int IW3 = 2;
`ifdef FLAG_BANK_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*IW-1:0] req_idx = '0;
  logic [NR-1:0]    req_val = '0;
  logic [NR-1:0]    ack;
  logic             busy;
  logic [NC-1:0]    flags;
  logic             err;

  logic [NR3-1:0]     req3 = '0;
  logic [NR3*IW3-1:0] req_idx3 = '0;
  logic [NR3-1:0]     req_val3 = '0;
  logic [NR3-1:0]     ack3;
  logic               busy3;
  logic [NC3-1:0]     flags3;
  logic               err3;

  int vectors = 0;
  int miscompares = 0;

  logic [NC-1:0] flags_m;
  int            ptr_m;

  always #5 clk = ~clk;

  flag_bank_arbiter #(.NUM_REQ(NR), .NUM_CELL(NC), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_idx(req_idx), .req_val(req_val),
    .ack(ack), .busy(busy), .flags(flags), .err(err)
  );

  flag_bank_arbiter #(.NUM_REQ(NR3), .NUM_CELL(NC3), .IDX_W(IW3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_idx(req_idx3), .req_val(req_val3),
    .ack(ack3), .busy(busy3), .flags(flags3), .err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0; req3 = '0;
    @(negedge clk);
    rst = 1'b0;
    flags_m = '0;
    ptr_m   = 0;
  endtask

  function automatic int model_pick(input logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      if (r[(ptr_m + i) % NR]) return (ptr_m + i) % NR;
    end
    return -1;
  endfunction

  // One full grant: sample edge E0, then write edge E1. Caller leaves the DUT in IDLE.
  task automatic grant(input string tag, input bit scramble);
    int   w;
    int   e_idx;
    logic e_val;
    w     = model_pick(req);
    e_idx = int'(req_idx[w*IW +: IW]);
    e_val = req_val[w];
    tick();
    check({tag, "_ack"},  32'(ack),   32'(1 << w));
    check({tag, "_busy"}, 32'(busy),  32'd1);
    check({tag, "_pre"},  32'(flags), 32'(flags_m));
    if (scramble) begin
      req     = NR'($urandom);
      req_idx = (NR*IW)'($urandom);
      req_val = NR'($urandom);
    end
    tick();
    if (e_idx < NC) flags_m[e_idx] = e_val;
    ptr_m = (w + 1) % NR;
    check({tag, "_ack0"},  32'(ack),   32'd0);
    check({tag, "_busy0"}, 32'(busy),  32'd0);
    check({tag, "_flags"}, 32'(flags), 32'(flags_m));
    check({tag, "_err"},   32'(err),   32'd0);
  endtask

  initial begin
    flags_m = '0;
    ptr_m   = 0;

    // Reset state
    rst = 1'b1;
    #12;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    do_reset();

    // Single write of 1 into cell 2
    req = 4'b0001; req_idx = 8'b00_00_00_10; req_val = 4'b0001;
    grant("t1", 1'b0);
    req = '0;
    check("t1_flags_lit", 32'(flags), 32'b0100);
    tick();
    check("t1_idle_busy", 32'(busy), 32'd0);

    // All requesters held: order 0,1,2,3,0
    do_reset();
    req = 4'b1111; req_idx = {2'd3, 2'd2, 2'd1, 2'd0}; req_val = 4'b1111;
    for (int k = 0; k < 5; k++) grant("t2", 1'b0);
    check("t2_flags_lit", 32'(flags), 32'b1111);

    // Pointer wrap after grant to requester 2
    req = 4'b0100;
    grant("t3a", 1'b0);
    req = 4'b1001; req_idx = {2'd0, 2'd0, 2'd0, 2'd1}; req_val = 4'b0000;
    grant("t3b", 1'b0);
    req = 4'b0001;
    grant("t3c", 1'b0);
    req = '0;

    // Reset during WRITE discards the pending write
    do_reset();
    req = 4'b0010; req_idx = {2'd0, 2'd0, 2'd1, 2'd0}; req_val = 4'b0010;
    tick();
    check("t4_ack", 32'(ack), 32'b0010);
    check("t4_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t4_ack_rst", 32'(ack), 32'd0);
    check("t4_busy_rst", 32'(busy), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    flags_m = '0; ptr_m = 0;
    tick();
    tick();
    check("t4_flags", 32'(flags), 32'd0);

    // Randomized traffic, inputs scrambled during WRITE
    for (int n = 0; n < 60; n++) begin
      req     = NR'($urandom_range(0, 15));
      req_idx = (NR*IW)'($urandom);
      req_val = NR'($urandom);
      if (req == '0) begin
        tick();
        check("rnd_idle_ack", 32'(ack), 32'd0);
        check("rnd_idle_busy", 32'(busy), 32'd0);
        check("rnd_idle_flags", 32'(flags), 32'(flags_m));
      end else begin
        grant("rnd", ($urandom_range(0, 1) == 1));
      end
    end
    req = '0;

    // Out-of-range index on a 3-cell bank
    do_reset();
    check("t5_err_rst", 32'(err3), 32'd0);
    req3 = 2'b01; req_idx3 = {2'd0, 2'd3}; req_val3 = 2'b01;
    tick();
    check("t5_ack", 32'(ack3), 32'b01);
    check("t5_busy", 32'(busy3), 32'd1);
    check("t5_err", 32'(err3), 32'(ERR_EXP));
    req3 = '0;
    tick();
    check("t5_ack0", 32'(ack3), 32'd0);
    check("t5_flags", 32'(flags3), 32'd0);
    check("t5_err_hold", 32'(err3), 32'(ERR_EXP));
    req3 = 2'b10; req_idx3 = {2'd1, 2'd0}; req_val3 = 2'b10;
    tick();
    check("t5_ack_b", 32'(ack3), 32'b10);
    req3 = '0;
    tick();
    check("t5_flags_b", 32'(flags3), 32'b010);
    check("t5_err_sticky", 32'(err3), 32'(ERR_EXP));
    tick();
    check("t5_err_sticky2", 32'(err3), 32'(ERR_EXP));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
